// File: rtl/ov7670_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_frame_reader
// Purpose  : Scans a completed RGB565 frame out of the capture block RAM once
//            the capture side signals end of frame. Each pixel is converted to
//            8-bit luma and emitted as a raster-ordered valid/ready stream with
//            start-of-frame, end-of-line and end-of-frame markers.
// Ports    : clk, rst_n         - system clock, async active-low reset
//            enable             - permits starting a new scan
//            end_of_frame       - capture-side level (other clock domain)
//            rd_addr/rd_en      - BRAM read port (1-cycle read latency)
//            rd_data            - RGB565 word {R[15:11], G[10:5], B[4:0]}
//            pix_data/valid/ready, pix_sof/eol/eof - luma output stream
//            busy               - scan in progress
//            overrun            - 1-cycle pulse on a frame edge while busy
// Revision : 1.0 - initial release
// ============================================================================
module ov7670_frame_reader #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              end_of_frame,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [15:0]       rd_data,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              busy,
    output logic              overrun
);

    localparam int c_X_W   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int c_Y_W   = (HEIGHT > 1) ? $clog2(HEIGHT + 1) : 1;
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_X_W-1:0]   c_X_LAST = c_X_W'(WIDTH - 1);
    localparam logic [c_Y_W-1:0]   c_Y_LAST = c_Y_W'(HEIGHT - 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH  = c_CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READ  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    // ------------------------------------------------------------------
    // end_of_frame synchroniser: two metastability flops plus a history
    // flop for rising-edge detection.
    // ------------------------------------------------------------------
    logic r_eof_s1, r_eof_s2, r_eof_s3;
    logic w_frame_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eof_s1 <= 1'b0;
            r_eof_s2 <= 1'b0;
            r_eof_s3 <= 1'b0;
        end else begin
            r_eof_s1 <= end_of_frame;
            r_eof_s2 <= r_eof_s1;
            r_eof_s3 <= r_eof_s2;
        end
    end

    assign w_frame_edge = r_eof_s2 & ~r_eof_s3;

    // ------------------------------------------------------------------
    // Scan state, address and raster position
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [c_X_W-1:0]  r_x;
    logic [c_Y_W-1:0]  r_y;

    logic              r_rd_pend;      // read issued last cycle, data on rd_data now
    logic [2:0]        r_pend_mark;    // {sof, eol, eof} of that read
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_wptr, r_rptr;
    logic [10:0]       r_mem [FIFO_DEPTH];
    logic              r_overrun;

    logic [c_CNT_W-1:0] w_outstanding;
    logic               w_issue;
    logic               w_last_col;
    logic               w_sof, w_eol, w_eof;
    logic               w_drain_done;
    logic               w_push, w_pop, w_valid;
    logic [10:0]        w_head;

    // A read is only issued if its result is guaranteed a FIFO slot, counting
    // the read still in flight; this is what keeps the FIFO from overflowing.
    assign w_outstanding = r_count + c_CNT_W'(r_rd_pend);
    assign w_issue       = (r_state == c_ST_READ) && (w_outstanding < c_DEPTH);

    assign w_last_col = (r_x == c_X_LAST);
    assign w_sof      = (r_x == '0) && (r_y == '0);
    assign w_eol      = w_last_col;
    assign w_eof      = w_last_col && (r_y == c_Y_LAST);

    assign w_drain_done = (r_state == c_ST_DRAIN) && (r_count == '0) && !r_rd_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_addr  <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_frame_edge && enable) begin
                        r_state <= c_ST_READ;
                        r_addr  <= '0;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                c_ST_READ: begin
                    if (w_issue) begin
                        r_addr <= r_addr + ADDR_W'(1);
                        if (w_last_col) begin
                            r_x <= '0;
                            r_y <= r_y + c_Y_W'(1);
                        end else begin
                            r_x <= r_x + c_X_W'(1);
                        end
                        if (w_eof) begin
                            r_state <= c_ST_DRAIN;
                        end
                    end
                end
                c_ST_DRAIN: begin
                    if (w_drain_done) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Markers follow their read through the one-cycle BRAM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pend   <= 1'b0;
            r_pend_mark <= 3'b000;
        end else begin
            r_rd_pend <= w_issue;
            if (w_issue) begin
                r_pend_mark <= {w_sof, w_eol, w_eof};
            end
        end
    end

    // ------------------------------------------------------------------
    // RGB565 -> luma. Channels are widened by bit replication so full-scale
    // inputs map to 255; the weights sum to 256, so the result fits 8 bits.
    // ------------------------------------------------------------------
    logic [7:0]  w_r8, w_g8, w_b8, w_luma;
    logic [15:0] w_sum;

    assign w_r8   = {rd_data[15:11], rd_data[15:13]};
    assign w_g8   = {rd_data[10:5],  rd_data[10:9]};
    assign w_b8   = {rd_data[4:0],   rd_data[4:2]};
    assign w_sum  = 16'd77  * {8'd0, w_r8}
                  + 16'd150 * {8'd0, w_g8}
                  + 16'd29  * {8'd0, w_b8};
    assign w_luma = 8'(w_sum >> 8);

    // ------------------------------------------------------------------
    // Output FIFO, entries {sof, eol, eof, luma}
    // ------------------------------------------------------------------
    assign w_push  = r_rd_pend;
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && pix_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {r_pend_mark, w_luma};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_frame_edge && (r_state != c_ST_IDLE);
        end
    end

    // FIFO storage is not reset, so the head is masked while empty to keep
    // the stream outputs at zero after reset.
    assign w_head    = r_mem[r_rptr];
    assign pix_valid = w_valid;
    assign pix_data  = w_valid ? w_head[7:0] : 8'd0;
    assign pix_sof   = w_valid & w_head[10];
    assign pix_eol   = w_valid & w_head[9];
    assign pix_eof   = w_valid & w_head[8];

    assign rd_addr = r_addr;
    assign rd_en   = w_issue;
    // busy drops in the same cycle the drain completes.
    assign busy    = (r_state != c_ST_IDLE) && !w_drain_done;
    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ov7670_frame_reader
// Purpose  : Self-checking bench for ov7670_frame_reader with a behavioural
//            BRAM, hand-computed luma vectors and a reference stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ov7670_frame_reader;

    localparam int WIDTH      = 160;
    localparam int HEIGHT     = 120;
    localparam int ADDR_W     = 17;
    localparam int FIFO_DEPTH = 4;
    localparam int NPIX       = WIDTH * HEIGHT;

    logic              clk          = 1'b0;
    logic              rst_n        = 1'b0;
    logic              enable       = 1'b0;
    logic              end_of_frame = 1'b0;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [15:0]       rd_data      = 16'd0;
    logic [7:0]        pix_data;
    logic              pix_valid;
    logic              pix_ready    = 1'b0;
    logic              pix_sof, pix_eol, pix_eof;
    logic              busy;
    logic              overrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    int n_issued, n_popped, n_ovr;
    int first_rd_cyc, last_rd_cyc, busy_fall_cyc;
    int outst;
    bit mon_on   = 1'b0;
    bit rnd_mode = 1'b0;
    bit prev_stall, prev_busy;
    logic [10:0] prev_word;
    logic [7:0]  first5 [5];
    logic [15:0] bram [NPIX];

    ov7670_frame_reader #(
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .end_of_frame (end_of_frame),
        .rd_addr      (rd_addr),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_sof      (pix_sof),
        .pix_eol      (pix_eol),
        .pix_eof      (pix_eof),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural BRAM read port: one-cycle latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= bram[rd_addr];
    end

    // Random backpressure, about 30% ready.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) pix_ready = ($urandom_range(0, 99) < 30);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int i);
        case (i)
            0:       return 16'hFFFF;
            1:       return 16'hF800;
            2:       return 16'h07E0;
            3:       return 16'h001F;
            4:       return 16'h0000;
            default: return 16'(i * 37 + 11);
        endcase
    endfunction

    function automatic logic [7:0] luma(input logic [15:0] w);
        int r5, g6, b5, r8, g8, b8;
        r5 = int'(w[15:11]);
        g6 = int'(w[10:5]);
        b5 = int'(w[4:0]);
        r8 = (r5 << 3) | (r5 >> 2);
        g8 = (g6 << 2) | (g6 >> 4);
        b8 = (b5 << 3) | (b5 >> 2);
        return 8'((77 * r8 + 150 * g8 + 29 * b8) >> 8);
    endfunction

    function automatic logic [10:0] exp_word(input int k);
        logic s, l, e;
        s = (k == 0);
        l = ((k % WIDTH) == WIDTH - 1);
        e = (k == NPIX - 1);
        return {s, l, e, luma(pat(k))};
    endfunction

    // Stream monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n || !mon_on) begin
            prev_stall = 1'b0;
            prev_busy  = 1'b0;
        end else begin
            outst = n_issued - n_popped;
            if (prev_stall) begin
                check("stall_valid", pix_valid, 1);
                check("stall_hold", {pix_sof, pix_eol, pix_eof, pix_data}, prev_word);
            end
            if (n_issued > 0) begin
                check("rd_en_credit", rd_en, (n_issued < NPIX) && (outst < FIFO_DEPTH));
            end
            if (rd_en) begin
                check("rd_addr", rd_addr, n_issued);
                if (n_issued == 0) first_rd_cyc = cyc;
                last_rd_cyc = cyc;
                n_issued++;
            end
            if (pix_valid && pix_ready) begin
                if (n_popped >= NPIX) begin
                    check("extra_beat", n_popped, NPIX - 1);
                end else begin
                    check($sformatf("beat%0d", n_popped),
                          {pix_sof, pix_eol, pix_eof, pix_data}, exp_word(n_popped));
                    if (n_popped < 5) first5[n_popped] = pix_data;
                end
                n_popped++;
            end
            if (overrun) n_ovr++;
            if (prev_busy && !busy) busy_fall_cyc = cyc;
            prev_busy  = busy;
            prev_stall = pix_valid && !pix_ready;
            prev_word  = {pix_sof, pix_eol, pix_eof, pix_data};
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_eof();
        end_of_frame = 1'b1;
        tick(4);
        end_of_frame = 1'b0;
        tick(1);
    endtask

    task automatic clear_counts();
        n_issued     = 0;
        n_popped     = 0;
        n_ovr        = 0;
        first_rd_cyc = -1;
        last_rd_cyc  = -1;
        busy_fall_cyc = -1;
    endtask

    task automatic start_frame(input string tag);
        int pulse_cyc;
        int k;
        clear_counts();
        pulse_cyc = cyc;
        pulse_eof();
        k = 0;
        while (first_rd_cyc < 0 && k < 20) begin
            tick(1);
            k++;
        end
        check({tag, "_start_lat"},
              (first_rd_cyc >= 0) && (first_rd_cyc - pulse_cyc >= 3) && (first_rd_cyc - pulse_cyc <= 4), 1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            tick(1);
            k++;
        end
        check({tag, "_done_timeout"}, busy, 0);
        tick(2);
    endtask

    task automatic wait_pop(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (n_popped < n && k < budget) begin
            tick(1);
            k++;
        end
        check({tag, "_pop_timeout"}, n_popped >= n, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_en"},     rd_en, 0);
        check({tag, "_rd_addr"},   rd_addr, 0);
        check({tag, "_pix_valid"}, pix_valid, 0);
        check({tag, "_pix_data"},  pix_data, 0);
        check({tag, "_pix_sof"},   pix_sof, 0);
        check({tag, "_pix_eol"},   pix_eol, 0);
        check({tag, "_pix_eof"},   pix_eof, 0);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_overrun"},   overrun, 0);
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) bram[i] = pat(i);
        clear_counts();

        // Reset state
        rst_n = 1'b0;
        tick(3);
        check_outputs_zero("rst");
        rst_n     = 1'b1;
        enable    = 1'b1;
        pix_ready = 1'b1;
        mon_on    = 1'b1;
        tick(2);

        // Frame A: no backpressure, hand-computed luma on the first beats
        start_frame("a");
        wait_done("a", 30000);
        check("a_beats",     n_popped, NPIX);
        check("a_issued",    n_issued, NPIX);
        check("a_rate",      last_rd_cyc - first_rd_cyc, NPIX - 1);
        check("a_busy_fall", busy_fall_cyc - last_rd_cyc, 3);
        check("a_overrun",   n_ovr, 0);
        check("luma_ffff", first5[0], 255);
        check("luma_f800", first5[1], 76);
        check("luma_07e0", first5[2], 149);
        check("luma_001f", first5[3], 28);
        check("luma_0000", first5[4], 0);

        // Frame B: random backpressure, second edge mid-scan
        rnd_mode = 1'b1;
        start_frame("b");
        wait_pop("b", 5000, 40000);
        pulse_eof();
        wait_done("b", 70000);
        rnd_mode  = 1'b0;
        pix_ready = 1'b1;
        check("b_beats",   n_popped, NPIX);
        check("b_issued",  n_issued, NPIX);
        check("b_overrun", n_ovr, 1);

        // Enable gating: an edge with enable low is ignored entirely
        tick(2);
        enable = 1'b0;
        clear_counts();
        pulse_eof();
        tick(20);
        check("gate_no_rd",   n_issued, 0);
        check("gate_no_ovr",  n_ovr, 0);
        check("gate_busy",    busy, 0);
        enable = 1'b1;
        tick(20);
        check("gate_late_rd",   n_issued, 0);
        check("gate_late_busy", busy, 0);

        // Next edge starts a new scan; reset it part way through
        start_frame("c");
        wait_pop("c", 100, 2000);
        mon_on = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        tick(3);
        check_outputs_zero("midrst_hold");
        rst_n = 1'b1;
        tick(2);
        mon_on = 1'b1;

        // Restart after reset: scan from address 0 with sof on beat 0
        start_frame("d");
        wait_pop("d", 300, 3000);
        check("d_first_sof_seen", n_popped >= 1, 1);
        check("d_overrun", n_ovr, 0);
        check("d_busy", busy, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
